cmp_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one compare unit between NUM_REQ requesters.
- Accepts a compare request (A, B, function), drives the compare unit's enable/operand/function inputs for exactly one cycle, and captures its registered result.
- Returns the result to the winning requester with a one-cycle valid pulse.
- Sits between the requester blocks and the shared compare unit in the ALU.

---
 rtl/cmp_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//
// Shares one compare unit between NUM_REQ requesters. A winning request is
// granted in IDLE, its operands are latched, the compare unit is enabled for
// exactly one cycle (ISSUE), the registered result is captured (WAIT) and then
// returned to the winner with a one-cycle valid pulse (RESP).
//
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE   (grant-to-response latency 3)
//
// Configuration macro:
//   CMP_ARB_FIXED_PRIO_EN  defined   : fixed priority, lowest active index wins,
//                                      no round-robin pointer.
//                          undefined : round-robin starting at the pointer,
//                                      pointer moves past the last served index.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   REQ        per-requester request, held until granted
//   REQ_A/B    flattened operands, requester i at [i*W +: W]
//   REQ_FUN    flattened compare function codes
//   GNT        one-hot grant pulse (IDLE only); operands sampled that cycle
//   RSP_VALID  one-hot response pulse (RESP only)
//   RSP_DATA   captured compare result, held until the next RESP
//   RSP_ERR    compare flag was low during ISSUE, held until the next RESP
//   RSP_ID     index of the responding requester (RESP only)
//   BUSY       high in ISSUE, WAIT and RESP
//   CMP_EN     compare unit enable, high in ISSUE only
//   CMP_A/B    compare unit operands from the operand latches
//   CMP_FUN    compare unit function from the function latch
//   CMP_RES    registered result from the compare unit
//   CMP_FLAG   compare unit flag, combinational on CMP_EN
// -----------------------------------------------------------------------------
module cmp_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDX_WIDTH     = 2,   // must equal clog2(NUM_REQ)
  parameter int A_WIDTH       = 16,
  parameter int B_WIDTH       = 16,
  parameter int ALU_FUN_WIDTH = 2,
  parameter int CMP_OUT_WIDTH = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               REQ,
  input  logic [NUM_REQ*A_WIDTH-1:0]       REQ_A,
  input  logic [NUM_REQ*B_WIDTH-1:0]       REQ_B,
  input  logic [NUM_REQ*ALU_FUN_WIDTH-1:0] REQ_FUN,
  output logic [NUM_REQ-1:0]               GNT,
  output logic [NUM_REQ-1:0]               RSP_VALID,
  output logic [CMP_OUT_WIDTH-1:0]         RSP_DATA,
  output logic                             RSP_ERR,
  output logic [IDX_WIDTH-1:0]             RSP_ID,
  output logic                             BUSY,
  output logic                             CMP_EN,
  output logic [A_WIDTH-1:0]               CMP_A,
  output logic [B_WIDTH-1:0]               CMP_B,
  output logic [ALU_FUN_WIDTH-1:0]         CMP_FUN,
  input  logic [CMP_OUT_WIDTH-1:0]         CMP_RES,
  input  logic                             CMP_FLAG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Arbitration
  logic [IDX_WIDTH-1:0]     rr_base;   // search start index
  logic [NUM_REQ-1:0]       req_rot;   // REQ rotated so rr_base lands on bit 0
  logic [IDX_WIDTH:0]       win_sum;   // rr_base + offset, one spare bit for wrap
  logic                     win_found;
  logic [IDX_WIDTH-1:0]     win_idx;
  logic [A_WIDTH-1:0]       win_a;
  logic [B_WIDTH-1:0]       win_b;
  logic [ALU_FUN_WIDTH-1:0] win_fun;

  // Operation latches and response registers
  logic [A_WIDTH-1:0]       a_q;
  logic [B_WIDTH-1:0]       b_q;
  logic [ALU_FUN_WIDTH-1:0] fun_q;
  logic [IDX_WIDTH-1:0]     idx_q;
  logic                     err_q;
  logic [CMP_OUT_WIDTH-1:0] rsp_data_q;
  logic                     rsp_err_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking assignments so every register
  // samples its pre-edge inputs, independent of process evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Search start point
  // ---------------------------------------------------------------------------
`ifdef CMP_ARB_FIXED_PRIO_EN
  // Fixed priority: always search upward from requester 0.
  assign rr_base = '0;
`else
  logic [IDX_WIDTH-1:0] ptr_q;

  // The pointer moves one past the requester just served, so a requester that
  // keeps REQ high yields to every other active requester before winning again.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q <= '0;
    end else if (state_q == S_RESP) begin
      ptr_q <= (idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_q + IDX_WIDTH'(1);
    end
  end

  assign rr_base = ptr_q;
`endif

  // ---------------------------------------------------------------------------
  // Winner selection: first set bit at or above rr_base, wrapping modulo
  // NUM_REQ. Rotating REQ first turns the wrap-around search into a plain
  // lowest-bit search; the offset is then mapped back to a real index.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default before
  // any conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    req_rot   = NUM_REQ'({REQ, REQ} >> rr_base);
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_sum = {1'b0, rr_base} + (IDX_WIDTH + 1)'(k);
      if (win_sum >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
        win_sum = win_sum - (IDX_WIDTH + 1)'(NUM_REQ);
      end
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_idx   = win_sum[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    win_a   = REQ_A[int'(win_idx) * A_WIDTH +: A_WIDTH];
    win_b   = REQ_B[int'(win_idx) * B_WIDTH +: B_WIDTH];
    win_fun = REQ_FUN[int'(win_idx) * ALU_FUN_WIDTH +: ALU_FUN_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    GNT       = '0;
    RSP_VALID = '0;
    RSP_ID    = '0;
    CMP_EN    = 1'b0;
    BUSY      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          // GNT is decoded straight from REQ, so it is also masked by RST to
          // keep every output at 0 while reset is held.
          GNT[win_idx] = RST;
        end
      end
      S_ISSUE: begin
        CMP_EN  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        RSP_VALID[idx_q] = 1'b1;
        RSP_ID           = idx_q;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latches, error bit and response registers
  // ---------------------------------------------------------------------------
  // NOTE: these datapath registers are reset on purpose: the compare-unit
  // operand outputs and the response fields must read 0 straight out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && win_found) begin
        a_q   <= win_a;
        b_q   <= win_b;
        fun_q <= win_fun;
        idx_q <= win_idx;
      end
      // The flag is only meaningful while CMP_EN is high.
      if (state_q == S_ISSUE) begin
        err_q <= ~CMP_FLAG;
      end
      // CMP_RES was registered by the compare unit at the end of ISSUE.
      // Result and error update together so both change only on a new response.
      if (state_q == S_WAIT) begin
        rsp_data_q <= CMP_RES;
        rsp_err_q  <= err_q;
      end
    end
  end

  assign CMP_A    = a_q;
  assign CMP_B    = b_q;
  assign CMP_FUN  = fun_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_ERR  = rsp_err_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmp_arbiter
//
// Self-checking bench for cmp_arbiter. A behavioural compare unit answers the
// DUT; a monitor pushes the expected response onto a scoreboard queue at every
// grant and pops/compares it at every response. Scenario tasks add their own
// cycle-accurate checks. Build with +define+CMP_ARB_FIXED_PRIO_EN to check the
// fixed-priority variant.
// -----------------------------------------------------------------------------
module tb_cmp_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int FW = 2;
  localparam int OW = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [N-1:0]      REQ;
  logic [N*AW-1:0]   REQ_A;
  logic [N*BW-1:0]   REQ_B;
  logic [N*FW-1:0]   REQ_FUN;
  logic [N-1:0]      GNT;
  logic [N-1:0]      RSP_VALID;
  logic [OW-1:0]     RSP_DATA;
  logic              RSP_ERR;
  logic [IW-1:0]     RSP_ID;
  logic              BUSY;
  logic              CMP_EN;
  logic [AW-1:0]     CMP_A;
  logic [BW-1:0]     CMP_B;
  logic [FW-1:0]     CMP_FUN;
  logic [OW-1:0]     CMP_RES;
  logic              CMP_FLAG;

  logic              flag_low = 1'b0;   // compare unit holds its flag low

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  valid;
    logic [IW-1:0] id;
    logic [OW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_w;
  int   m_ptr = 0;
  int   gnt_count[N];

  cmp_arbiter #(
    .NUM_REQ(N), .IDX_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW),
    .ALU_FUN_WIDTH(FW), .CMP_OUT_WIDTH(OW)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_FUN(REQ_FUN), .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .RSP_ERR(RSP_ERR), .RSP_ID(RSP_ID), .BUSY(BUSY), .CMP_EN(CMP_EN),
    .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_FUN(CMP_FUN), .CMP_RES(CMP_RES),
    .CMP_FLAG(CMP_FLAG)
  );

  always #5 CLK = ~CLK;

  // 01 equal, 10 greater-than, 11 less-than; result is the code when true.
  function automatic logic [OW-1:0] cmp_model(input logic [AW-1:0] a,
                                              input logic [BW-1:0] b,
                                              input logic [FW-1:0] f);
    case (f)
      2'b01:   return (a == b) ? 2'b01 : 2'b00;
      2'b10:   return (a >  b) ? 2'b10 : 2'b00;
      2'b11:   return (a <  b) ? 2'b11 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int model_winner(input logic [N-1:0] r, input int p);
    int start;
    start = p;
`ifdef CMP_ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Behavioural compare unit: registered result, flag combinational on enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) CMP_RES <= '0;
    else if (CMP_EN) CMP_RES <= cmp_model(CMP_A, CMP_B, CMP_FUN);
  end
  assign CMP_FLAG = CMP_EN & ~flag_low;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      sb_q.delete();
      m_ptr = 0;
    end else begin
      if (GNT !== '0) begin
        mon_w = model_winner(REQ, m_ptr);
        checks++;
        if (mon_w < 0 || GNT !== (N'(1) << mon_w)) begin
          errors++;
          $display("FAIL gnt_winner: GNT=%b REQ=%b required winner %0d", GNT, REQ, mon_w);
        end
        if (mon_w >= 0) begin
          mon_e.valid = N'(1) << mon_w;
          mon_e.id    = IW'(mon_w);
          mon_e.data  = cmp_model(REQ_A[mon_w*AW +: AW], REQ_B[mon_w*BW +: BW],
                                  REQ_FUN[mon_w*FW +: FW]);
          mon_e.err   = flag_low;
          sb_q.push_back(mon_e);
          gnt_count[mon_w]++;
        end
      end
      if (RSP_VALID !== '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: RSP_VALID=%b with no outstanding grant", RSP_VALID);
        end else begin
          mon_e = sb_q.pop_front();
          if (RSP_VALID !== mon_e.valid) begin
            errors++;
            $display("FAIL rsp_valid: got %b expected %b", RSP_VALID, mon_e.valid);
          end
          checks++;
          if (RSP_ID !== mon_e.id) begin
            errors++;
            $display("FAIL rsp_id: got %0d expected %0d", RSP_ID, mon_e.id);
          end
          checks++;
          if (RSP_DATA !== mon_e.data) begin
            errors++;
            $display("FAIL rsp_data: got %b expected %b", RSP_DATA, mon_e.data);
          end
          checks++;
          if (RSP_ERR !== mon_e.err) begin
            errors++;
            $display("FAIL rsp_err: got %b expected %b", RSP_ERR, mon_e.err);
          end
          m_ptr = (int'(mon_e.id) + 1) % N;
        end
      end
      checks++;
      if (CMP_EN && (!BUSY || GNT !== '0)) begin
        errors++;
        $display("FAIL cmp_en_state: CMP_EN=1 with BUSY=%b GNT=%b", BUSY, GNT);
      end
    end
  end

  task automatic set_ops(input int idx, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [FW-1:0] f);
    REQ_A[idx*AW +: AW]   = a;
    REQ_B[idx*BW +: BW]   = b;
    REQ_FUN[idx*FW +: FW] = f;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSY !== 1'b0 && n < 20);
    if (BUSY !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: BUSY=%b after %0d cycles, required 0", name, BUSY, n);
    end
  endtask

  // One full operation from requester idx; the scoreboard checks the response.
  task automatic do_op(input int idx, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [FW-1:0] f);
    int n;
    @(posedge CLK); #1;
    set_ops(idx, a, b, f);
    REQ[idx] = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (GNT[idx] !== 1'b1 && n < 20);
    if (GNT[idx] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL op_grant_timeout: no GNT[%0d] after %0d cycles, GNT=%b", idx, n, GNT);
    end
    @(posedge CLK); #1;
    REQ[idx] = 1'b0;
    wait_idle("op");
  endtask

  task automatic test_reset();
    REQ = '1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({GNT, RSP_VALID, RSP_DATA, RSP_ERR, RSP_ID, BUSY, CMP_EN, CMP_A, CMP_B, CMP_FUN} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: GNT=%b RSP_VALID=%b BUSY=%b CMP_EN=%b CMP_A=%h, required all 0",
               GNT, RSP_VALID, BUSY, CMP_EN, CMP_A);
    end
    REQ = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({GNT, BUSY, CMP_EN, RSP_VALID} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: GNT=%b BUSY=%b CMP_EN=%b RSP_VALID=%b, required 0",
               GNT, BUSY, CMP_EN, RSP_VALID);
    end
  endtask

  task automatic test_single();
    @(posedge CLK); #1;
    set_ops(0, 16'd5, 16'd3, 2'b10);
    REQ = 4'b0001;
    @(negedge CLK);  // cycle 0: IDLE
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b0 || CMP_EN !== 1'b0) begin
      errors++;
      $display("FAIL single_c0: GNT=%b BUSY=%b CMP_EN=%b, required 0001/0/0", GNT, BUSY, CMP_EN);
    end
    @(posedge CLK); #1;
    REQ = '0;
    @(negedge CLK);  // cycle 1: ISSUE
    checks++;
    if (CMP_EN !== 1'b1 || BUSY !== 1'b1 || GNT !== '0 ||
        CMP_A !== 16'd5 || CMP_B !== 16'd3 || CMP_FUN !== 2'b10) begin
      errors++;
      $display("FAIL single_c1: CMP_EN=%b BUSY=%b GNT=%b A=%0d B=%0d FUN=%b, required 1/1/0000/5/3/10",
               CMP_EN, BUSY, GNT, CMP_A, CMP_B, CMP_FUN);
    end
    @(negedge CLK);  // cycle 2: WAIT
    checks++;
    if (CMP_EN !== 1'b0 || BUSY !== 1'b1 || RSP_VALID !== '0 || CMP_A !== 16'd5) begin
      errors++;
      $display("FAIL single_c2: CMP_EN=%b BUSY=%b RSP_VALID=%b CMP_A=%0d, required 0/1/0000/5",
               CMP_EN, BUSY, RSP_VALID, CMP_A);
    end
    @(negedge CLK);  // cycle 3: RESP
    checks++;
    if (RSP_VALID !== 4'b0001 || RSP_DATA !== 2'b10 || RSP_ID !== 2'd0 ||
        RSP_ERR !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_c3: RSP_VALID=%b DATA=%b ID=%0d ERR=%b BUSY=%b, required 0001/10/0/0/1",
               RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY);
    end
    @(negedge CLK);  // cycle 4: back in IDLE, data held
    checks++;
    if (BUSY !== 1'b0 || RSP_VALID !== '0 || RSP_DATA !== 2'b10) begin
      errors++;
      $display("FAIL single_c4: BUSY=%b RSP_VALID=%b RSP_DATA=%b, required 0/0000/10",
               BUSY, RSP_VALID, RSP_DATA);
    end
  endtask

  task automatic test_compare();
    logic [OW-1:0] exp_data[4];
    logic [AW-1:0] a_tab[4];
    logic [BW-1:0] b_tab[4];
    logic [FW-1:0] f_tab[4];
    a_tab = '{16'd7, 16'd2, 16'd9, 16'd4};
    b_tab = '{16'd7, 16'd9, 16'd2, 16'd4};
    f_tab = '{2'b01, 2'b11, 2'b11, 2'b00};
    exp_data = '{2'b01, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      do_op(2, a_tab[i], b_tab[i], f_tab[i]);
      checks++;
      if (RSP_DATA !== exp_data[i] || RSP_ERR !== 1'b0) begin
        errors++;
        $display("FAIL compare_%0d: RSP_DATA=%b RSP_ERR=%b, required %b/0",
                 i, RSP_DATA, RSP_ERR, exp_data[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[16];
    int got;
    int n;
    int exp_id;
    do_op(3, 16'd1, 16'd1, 2'b01);  // serve requester 3 so the pointer sits at 0
    for (int i = 0; i < N; i++) begin
      set_ops(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              2'($urandom_range(0, 3)));
    end
    @(posedge CLK); #1;
    REQ = '1;
    got = 0;
    n = 0;
    while (got < 16 && n < 100) begin
      @(negedge CLK);
      n++;
      for (int i = 0; i < N; i++) begin
        if (GNT[i]) order[got] = i;
      end
      if (GNT !== '0) got++;
    end
    @(posedge CLK); #1;
    REQ = '0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL rr_grant_count: saw %0d grants, required 16", got);
    end
    for (int i = 0; i < got; i++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % N;
`endif
      checks++;
      if (order[i] != exp_id) begin
        errors++;
        $display("FAIL rr_order_%0d: granted %0d, required %0d", i, order[i], exp_id);
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_error();
    flag_low = 1'b1;
    do_op(1, 16'd8, 16'd8, 2'b01);
    checks++;
    if (RSP_ERR !== 1'b1) begin
      errors++;
      $display("FAIL error_flag_low: RSP_ERR=%b, required 1", RSP_ERR);
    end
    flag_low = 1'b0;
    do_op(1, 16'd3, 16'd8, 2'b11);
    checks++;
    if (RSP_ERR !== 1'b0 || RSP_DATA !== 2'b11) begin
      errors++;
      $display("FAIL error_recover: RSP_ERR=%b RSP_DATA=%b, required 0/11", RSP_ERR, RSP_DATA);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    set_ops(1, 16'd6, 16'd5, 2'b10);
    REQ = 4'b0010;
    @(negedge CLK);   // IDLE, grant
    @(posedge CLK); #1;
    REQ = '0;         // ISSUE
    @(posedge CLK); #1;
    RST = 1'b0;       // during WAIT
    #1;
    checks++;
    if ({GNT, RSP_VALID, RSP_DATA, RSP_ERR, RSP_ID, BUSY, CMP_EN, CMP_A, CMP_B, CMP_FUN} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: BUSY=%b RSP_DATA=%b CMP_A=%h CMP_FUN=%b, required all 0",
               BUSY, RSP_DATA, CMP_A, CMP_FUN);
    end
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);  // an aborted response here trips the scoreboard
    // Pointer must be back at 0: with both 0 and 2 requesting, 0 wins.
    @(posedge CLK); #1;
    set_ops(0, 16'd1, 16'd2, 2'b11);
    set_ops(2, 16'd2, 16'd1, 2'b10);
    REQ = 4'b0101;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_ptr: GNT=%b, required 0001", GNT);
    end
    @(posedge CLK); #1;
    REQ = '0;
    wait_idle("reset_mid");
    @(posedge CLK); #1;
    REQ = 4'b0100;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_gnt: GNT=%b, required 0100", GNT);
    end
    @(posedge CLK); #1;
    REQ = '0;
    wait_idle("reset_mid2");
  endtask

  task automatic test_busy_toggle();
    int gnt3_before;
    gnt3_before = gnt_count[3];
    @(posedge CLK); #1;
    set_ops(0, 16'd4, 16'd4, 2'b01);
    set_ops(1, 16'd1, 16'd9, 2'b11);
    set_ops(3, 16'd9, 16'd1, 2'b10);
    REQ = 4'b0001;
    @(negedge CLK);   // IDLE, grant 0
    @(posedge CLK); #1;
    REQ = 4'b1000;    // ISSUE
    @(negedge CLK);
    checks++;
    if (GNT !== '0) begin
      errors++;
      $display("FAIL toggle_issue: GNT=%b, required 0000", GNT);
    end
    @(posedge CLK); #1;
    REQ = 4'b0000;    // WAIT
    @(negedge CLK);
    checks++;
    if (GNT !== '0) begin
      errors++;
      $display("FAIL toggle_wait: GNT=%b, required 0000", GNT);
    end
    @(posedge CLK); #1;
    REQ = 4'b0010;    // RESP
    @(negedge CLK);
    checks++;
    if (GNT !== '0 || RSP_VALID !== 4'b0001) begin
      errors++;
      $display("FAIL toggle_resp: GNT=%b RSP_VALID=%b, required 0000/0001", GNT, RSP_VALID);
    end
    @(negedge CLK);   // IDLE again
    checks++;
    if (GNT !== 4'b0010) begin
      errors++;
      $display("FAIL toggle_idle_gnt: GNT=%b, required 0010", GNT);
    end
    @(posedge CLK); #1;
    REQ = '0;
    wait_idle("toggle");
    checks++;
    if (gnt_count[3] != gnt3_before) begin
      errors++;
      $display("FAIL toggle_no_gnt3: %0d grants to 3, required 0", gnt_count[3] - gnt3_before);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    REQ     = '0;
    REQ_A   = '0;
    REQ_B   = '0;
    REQ_FUN = '0;
    for (int i = 0; i < N; i++) gnt_count[i] = 0;

    test_reset();
    test_single();
    test_compare();
    test_round_robin();
    test_error();
    test_reset_mid();
    test_busy_toggle();

    repeat (4) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
